// File: rtl/ternary_mac_sequencer.sv
// Sequences one dot-product job on the ternary systolic MAC array. The job runs
// clear -> stream k_len operand beats -> copy accumulators -> frame N_ROWS readout bytes.
module ternary_mac_sequencer #(
  parameter int unsigned K_W    = 8,
  parameter int unsigned N_ROWS = 4,
  localparam int unsigned ROW_W = $clog2(N_ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [K_W-1:0]   k_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_weights,
  input  logic [7:0]       in_act,
  output logic [7:0]       arr_weights,
  output logic [7:0]       arr_top,
  output logic             arr_reset_acc,
  output logic             arr_copy,
  output logic             arr_restart_q,
  input  logic [7:0]       arr_out,
  output logic             out_valid,
  output logic [ROW_W-1:0] out_row,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StClear, StAccum, StReadout} state_e;

  state_e           state_q;
  logic [K_W-1:0]   cnt_q;
  logic [K_W-1:0]   k_len_q;
  logic [ROW_W-1:0] row_q;

  logic aborting;
  logic beat;
  logic last_beat;
  logic last_row;

  assign aborting  = abort && (state_q != StIdle);
  assign beat      = (state_q == StAccum) && in_valid && !abort;
  assign last_beat = beat && (cnt_q == k_len_q - K_W'(1));
  assign last_row  = (row_q == ROW_W'(N_ROWS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      k_len_q <= '0;
      row_q   <= '0;
    end else if (aborting) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && (k_len != '0)) begin
            k_len_q <= k_len;
            cnt_q   <= '0;
            state_q <= StClear;
          end
        end
        StClear: state_q <= StAccum;
        StAccum: begin
          if (last_beat) begin
            row_q   <= '0;
            state_q <= StReadout;
          end else if (beat) begin
            cnt_q <= cnt_q + K_W'(1);
          end
        end
        StReadout: begin
          row_q <= row_q + ROW_W'(1);
          if (last_row) begin
            row_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array accumulates every cycle, so operands are zeroed unless a beat is accepted.
  // Everything is forced low while reset is held so outputs clear without waiting for an edge.
  always_comb begin
    in_ready      = 1'b0;
    arr_weights   = '0;
    arr_top       = '0;
    arr_reset_acc = 1'b0;
    arr_copy      = 1'b0;
    arr_restart_q = 1'b0;
    out_valid     = 1'b0;
    out_row       = '0;
    out_data      = '0;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    if (!reset) begin
      in_ready      = (state_q == StAccum) && !abort;
      if (beat) begin
        arr_weights = in_weights;
        arr_top     = in_act;
      end
      arr_reset_acc = (state_q == StClear) || aborting;
      arr_copy      = last_beat;
      arr_restart_q = last_beat;
      out_valid     = (state_q == StReadout) && !abort;
      if (out_valid) begin
        out_row  = row_q;
        out_data = arr_out;
        done     = last_row;
      end
      busy = (state_q != StIdle);
      err  = (state_q == StIdle) && start && (k_len == '0);
    end
  end

endmodule

// File: tb/tb_ternary_mac_sequencer.sv
// Directed bench for ternary_mac_sequencer: inputs driven 2 time units after each
// rising edge, outputs checked 1 unit later, expected values written by hand.
module tb_ternary_mac_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] k_len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_weights;
  logic [7:0] in_act;
  logic [7:0] arr_weights;
  logic [7:0] arr_top;
  logic       arr_reset_acc;
  logic       arr_copy;
  logic       arr_restart_q;
  logic [7:0] arr_out;
  logic       out_valid;
  logic [1:0] out_row;
  logic [7:0] out_data;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  ternary_mac_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .k_len         (k_len),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_weights    (in_weights),
    .in_act        (in_act),
    .arr_weights   (arr_weights),
    .arr_top       (arr_top),
    .arr_reset_acc (arr_reset_acc),
    .arr_copy      (arr_copy),
    .arr_restart_q (arr_restart_q),
    .arr_out       (arr_out),
    .out_valid     (out_valid),
    .out_row       (out_row),
    .out_data      (out_data),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  // k_len=4, four back-to-back +1 x4 beats of 0x7F; the array reports 0x01 per row.
  task automatic job1();
    next();
    start = 1'b1; k_len = 8'd4; #1;
    chk("j1_idle_busy", {31'b0, busy}, 0);
    chk("j1_idle_ready", {31'b0, in_ready}, 0);
    next();
    start = 1'b0; #1;
    chk("j1_clear_rst", {31'b0, arr_reset_acc}, 1);
    chk("j1_clear_ready", {31'b0, in_ready}, 0);
    chk("j1_clear_busy", {31'b0, busy}, 1);
    for (int b = 0; b < 4; b++) begin
      next();
      in_valid = 1'b1; in_weights = 8'h55; in_act = 8'h7F; #1;
      chk("j1_ready", {31'b0, in_ready}, 1);
      chk("j1_weights", {24'b0, arr_weights}, 32'h55);
      chk("j1_top", {24'b0, arr_top}, 32'h7F);
      chk("j1_copy", {31'b0, arr_copy}, (b == 3) ? 1 : 0);
      chk("j1_restart", {31'b0, arr_restart_q}, (b == 3) ? 1 : 0);
      chk("j1_no_out", {31'b0, out_valid}, 0);
    end
    for (int r = 0; r < 4; r++) begin
      next();
      in_valid = 1'b0; arr_out = 8'h01; #1;
      chk("j1_out_valid", {31'b0, out_valid}, 1);
      chk("j1_out_row", {30'b0, out_row}, r);
      chk("j1_out_data", {24'b0, out_data}, 1);
      chk("j1_done", {31'b0, done}, (r == 3) ? 1 : 0);
      chk("j1_rd_ready", {31'b0, in_ready}, 0);
    end
    next();
    arr_out = 8'h00; #1;
    chk("j1_end_busy", {31'b0, busy}, 0);
    chk("j1_end_valid", {31'b0, out_valid}, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; k_len = 8'd0; in_valid = 1'b0;
    in_weights = 8'h00; in_act = 8'h00; arr_out = 8'h00;
    #3;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ready", {31'b0, in_ready}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_reset_acc", {31'b0, arr_reset_acc}, 0);
    next();
    next();
    reset = 1'b0;

    // Test 1
    job1();

    // Test 2: k_len=2 with a 3-cycle gap between beats
    next();
    start = 1'b1; k_len = 8'd2; #1;
    next();
    start = 1'b0; #1;
    chk("t2_clear", {31'b0, arr_reset_acc}, 1);
    next();
    in_valid = 1'b1; in_weights = 8'h5A; in_act = 8'h10; #1;
    chk("t2_b1_weights", {24'b0, arr_weights}, 32'h5A);
    chk("t2_b1_copy", {31'b0, arr_copy}, 0);
    for (int g = 0; g < 3; g++) begin
      next();
      in_valid = 1'b0; in_weights = 8'hFF; in_act = 8'h33; #1;
      chk("t2_gap_weights", {24'b0, arr_weights}, 0);
      chk("t2_gap_top", {24'b0, arr_top}, 0);
      chk("t2_gap_ready", {31'b0, in_ready}, 1);
      chk("t2_gap_copy", {31'b0, arr_copy}, 0);
      chk("t2_gap_out", {31'b0, out_valid}, 0);
    end
    next();
    in_valid = 1'b1; in_weights = 8'h96; in_act = 8'h81; #1;
    chk("t2_b2_weights", {24'b0, arr_weights}, 32'h96);
    chk("t2_b2_top", {24'b0, arr_top}, 32'h81);
    chk("t2_b2_copy", {31'b0, arr_copy}, 1);
    chk("t2_b2_out", {31'b0, out_valid}, 0);
    for (int r = 0; r < 4; r++) begin
      next();
      in_valid = 1'b0; arr_out = 8'hC0 + 8'(r); #1;
      chk("t2_out_row", {30'b0, out_row}, r);
      chk("t2_out_data", {24'b0, out_data}, 32'hC0 + r);
      chk("t2_done", {31'b0, done}, (r == 3) ? 1 : 0);
    end
    next();
    arr_out = 8'h00; #1;
    chk("t2_end_busy", {31'b0, busy}, 0);

    // Test 3: start with k_len=0
    next();
    start = 1'b1; k_len = 8'd0; #1;
    chk("t3_err", {31'b0, err}, 1);
    chk("t3_rst_acc", {31'b0, arr_reset_acc}, 0);
    next();
    start = 1'b0; #1;
    chk("t3_err_pulse", {31'b0, err}, 0);
    chk("t3_busy", {31'b0, busy}, 0);
    chk("t3_no_clear", {31'b0, arr_reset_acc}, 0);

    // Test 4: start held high; second CLEAR only after done
    next();
    start = 1'b1; k_len = 8'd1; #1;
    next();
    #1;
    chk("t4_clear1", {31'b0, arr_reset_acc}, 1);
    next();
    in_valid = 1'b1; in_weights = 8'h01; in_act = 8'h02; #1;
    chk("t4_copy", {31'b0, arr_copy}, 1);
    chk("t4_accum_rst", {31'b0, arr_reset_acc}, 0);
    for (int r = 0; r < 4; r++) begin
      next();
      in_valid = 1'b0; #1;
      chk("t4_rd_rst", {31'b0, arr_reset_acc}, 0);
      chk("t4_done", {31'b0, done}, (r == 3) ? 1 : 0);
    end
    next();
    #1;
    chk("t4_idle_busy", {31'b0, busy}, 0);
    chk("t4_idle_rst", {31'b0, arr_reset_acc}, 0);
    next();
    start = 1'b0; abort = 1'b1; #1;
    chk("t4_clear2", {31'b0, arr_reset_acc}, 1);
    next();
    abort = 1'b0; #1;
    chk("t4_abort_idle", {31'b0, busy}, 0);

    // Test 5: abort during readout row 1
    next();
    start = 1'b1; k_len = 8'd1; #1;
    next();
    start = 1'b0; #1;
    next();
    in_valid = 1'b1; #1;
    next();
    in_valid = 1'b0; arr_out = 8'h77; #1;
    chk("t5_row0", {31'b0, out_valid}, 1);
    chk("t5_row0_rst", {31'b0, arr_reset_acc}, 0);
    next();
    abort = 1'b1; #1;
    chk("t5_ab_valid", {31'b0, out_valid}, 0);
    chk("t5_ab_data", {24'b0, out_data}, 0);
    chk("t5_ab_rst", {31'b0, arr_reset_acc}, 1);
    chk("t5_ab_done", {31'b0, done}, 0);
    next();
    abort = 1'b0; #1;
    chk("t5_idle_busy", {31'b0, busy}, 0);
    chk("t5_idle_valid", {31'b0, out_valid}, 0);
    chk("t5_idle_rst", {31'b0, arr_reset_acc}, 0);
    next();
    abort = 1'b1; #1;
    chk("t5_idle_abort", {31'b0, arr_reset_acc}, 0);
    next();
    abort = 1'b0; arr_out = 8'h00;

    // Test 6: async reset mid-ACCUM, then a fresh job
    start = 1'b1; k_len = 8'd4; #1;
    next();
    start = 1'b0; #1;
    next();
    in_valid = 1'b1; in_weights = 8'h55; in_act = 8'h7F; #1;
    next();
    #1;
    chk("t6_pre_ready", {31'b0, in_ready}, 1);
    reset = 1'b1; #1;
    chk("t6_rst_ready", {31'b0, in_ready}, 0);
    chk("t6_rst_weights", {24'b0, arr_weights}, 0);
    chk("t6_rst_top", {24'b0, arr_top}, 0);
    chk("t6_rst_busy", {31'b0, busy}, 0);
    chk("t6_rst_copy", {31'b0, arr_copy}, 0);
    next();
    in_valid = 1'b0;
    next();
    reset = 1'b0;
    job1();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
